// File: rtl/pagerank_pkg.sv
// Shared PageRank datapath definitions: rank-accumulator FSM states, fixed-point defaults
// and widths shared with the adder-tree reducer.
package pagerank_pkg;

    localparam int NBITS_DEFAULT = 32;
    localparam int LENW_DEFAULT  = 16;
    localparam int FRAC_DEFAULT  = 16;
    localparam logic [31:0] DAMP_Q16 = 32'h0000D99A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DAMP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pagerank_damp_mul.sv
// Damping step: rank = base + (acc * damp) >> frac. Wrapping by default; saturating on every
// stage when PAGERANK_RANK_ACCUM_SAT_EN is defined.
module pagerank_damp_mul
    import pagerank_pkg::*;
#(
    parameter int          nbits = NBITS_DEFAULT,
    parameter int          FRAC  = FRAC_DEFAULT,
    parameter logic [31:0] DAMP  = DAMP_Q16
) (
    input  logic [nbits-1:0] acc,
    input  logic [nbits-1:0] base,
    output logic [nbits-1:0] rank
);

    localparam logic [FRAC:0] DAMP_K = DAMP[FRAC:0];

    logic [nbits+FRAC:0] prod;
    logic [nbits-1:0]    scaled;
    logic                unused_bits;

    // Both operands widened to the full product width so no bit is lost.
    assign prod   = {{(FRAC+1){1'b0}}, acc} * {{nbits{1'b0}}, DAMP_K};
    assign unused_bits = ^{prod[nbits+FRAC], prod[FRAC-1:0]};

`ifdef PAGERANK_RANK_ACCUM_SAT_EN
    logic [nbits:0] sum;

    assign scaled = prod[nbits+FRAC] ? {nbits{1'b1}} : prod[FRAC+nbits-1:FRAC];
    assign sum    = {1'b0, base} + {1'b0, scaled};
    assign rank   = sum[nbits] ? {nbits{1'b1}} : sum[nbits-1:0];
`else
    assign scaled = prod[FRAC+nbits-1:FRAC];
    assign rank   = base + scaled;
`endif

endmodule

// File: rtl/pagerank_rank_accum.sv
// Per-vertex rank accumulator: sums len partial-sum beats, applies damping, emits one rank.
// Build option PAGERANK_RANK_ACCUM_SAT_EN switches all arithmetic to saturating.
module pagerank_rank_accum
    import pagerank_pkg::*;
#(
    parameter int          nbits = NBITS_DEFAULT,
    parameter int          FRAC  = FRAC_DEFAULT,
    parameter logic [31:0] DAMP  = DAMP_Q16,
    parameter int          LENW  = LENW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_val,
    output logic             cfg_rdy,
    input  logic [LENW-1:0]  cfg_len,
    input  logic [nbits-1:0] cfg_base,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_data,
    output logic             busy
);

    // Handshake: a transfer fires when val && rdy in the same cycle; every rdy/val output
    // is decoded from the state register only, never from the partner's val/rdy.

    state_t           state;
    logic [nbits-1:0] acc;
    logic [nbits-1:0] acc_next;
    logic [nbits-1:0] base_q;
    logic [nbits-1:0] damped;
    logic [LENW-1:0]  cnt;
    logic [LENW-1:0]  len_q;
    logic             cfg_fire;
    logic             in_fire;
    logic             out_fire;
    logic             last_beat;

    assign cfg_rdy  = (state == IDLE);
    assign in_rdy   = (state == ACC);
    assign out_val  = (state == DONE);
    assign busy     = (state != IDLE);

    assign cfg_fire  = cfg_val & cfg_rdy;
    assign in_fire   = in_val & in_rdy;
    assign out_fire  = out_val & out_rdy;
    assign last_beat = (cnt == len_q - 1'b1);

`ifdef PAGERANK_RANK_ACCUM_SAT_EN
    logic [nbits:0] acc_sum;

    always_comb begin
        acc_sum  = {1'b0, acc} + {1'b0, in_data};
        acc_next = acc_sum[nbits] ? {nbits{1'b1}} : acc_sum[nbits-1:0];
    end
`else
    always_comb begin
        acc_next = acc + in_data;
    end
`endif

    pagerank_damp_mul #(
        .nbits (nbits),
        .FRAC  (FRAC),
        .DAMP  (DAMP)
    ) u_damp_mul (
        .acc  (acc),
        .base (base_q),
        .rank (damped)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            base_q   <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        len_q  <= cfg_len;
                        base_q <= cfg_base;
                        acc    <= '0;
                        cnt    <= '0;
                        // An empty job skips straight to damping a zero sum.
                        state  <= (cfg_len == '0) ? pagerank_pkg::DAMP : ACC;
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= pagerank_pkg::DAMP;
                        end
                    end
                end
                pagerank_pkg::DAMP: begin
                    out_data <= damped;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_fire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
